envia_datos_rx: RTL and testbench
=================================

Name: envia_datos_rx

Overview:
- Serial-to-display bridge that receives 8N1 UART bytes on Rx, groups them into 32-byte (256-bit) packets, then shifts each packet out to a display shift-register chain.
- Outputs: serial data DO, shift clock CLKimpr, latch LAT and strobe STB.
- Sits between the host UART link and the display driver board. Reception continues while a packet is being shifted out.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (5208), clock cycles per UART bit.
- PKT_BYTES, 32, bytes per display packet.
- SHIFT_DIV, 4, CLK cycles per CLKimpr half-period.
- LAT_CYCLES, 4, LAT pulse width in CLK cycles.
- STB_CYCLES, 4, STB pulse width in CLK cycles.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous active-high reset.
- Rx  input  1  UART line, idle high, asynchronous to CLK.
- DO  output  1  serial display data.
- CLKimpr  output  1  display shift clock.
- LAT  output  1  display latch pulse, active high.
- STB  output  1  display strobe/output-enable pulse, active high.

Behaviour:
- Reset (RST high at a CLK edge):
  - DO=0, CLKimpr=0, LAT=0, STB=0.
  - Receiver returns to IDLE; byte counter = 0; buffer cleared; transmitter returns to IDLE.
- Rx passes through a 2-FF synchronizer before any use.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge of Rx.
  - START: at CLKS_PER_BIT/2 cycles, re-sample Rx. If Rx=0, go to DATA. If Rx=1, treat as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after one more CLKS_PER_BIT. If Rx=1, the byte is valid. If Rx=0 (framing error), discard the byte and do not advance the counter. Return to IDLE.
  - A byte is valid about 9.5 bit times after the start edge.
- Packing:
  - Valid byte k (k = 0..31) is written to buffer slot k; the byte counter then increments.
  - When slot 31 is written, the counter wraps to 0 and a 256-bit snapshot is copied to the transmit shift register in the same cycle.
  - Receiving then continues into the buffer.
- Transmitter FSM states: IDLE, SHIFT, LATCH, STROBE.
  - IDLE -> SHIFT on the snapshot load.
  - SHIFT:
    - 256 bits are sent, byte 0 first, MSB first within each byte.
    - DO updates while CLKimpr is low. CLKimpr goes high SHIFT_DIV cycles later and low after another SHIFT_DIV cycles.
    - Each bit takes 2*SHIFT_DIV cycles, so exactly 256 rising edges of CLKimpr.
  - LATCH: CLKimpr=0, DO=0, LAT=1 for LAT_CYCLES.
  - STROBE: STB=1 for STB_CYCLES, then IDLE.
  - A full transmit takes about 2080 cycles, far less than the 32-byte receive time, so no overrun is possible at the default parameters.
  - If a new snapshot arrives while not in IDLE, it is ignored; the current transmit completes unaffected.
- DO, CLKimpr, LAT and STB are registered outputs and are glitch-free.
- Partial packets are held until completed. Only RST clears them.

Decomposition:
- Shared package: CLKS_PER_BIT computation, PKT_BYTES, and receiver/transmitter state encodings.
- Natural sub-modules:
  - uart_rx: synchronizer plus receiver FSM. Outputs rx_data[7:0] and a one-cycle rx_valid pulse.
  - display_tx: transmitter FSM.
- The packing buffer stays in the top level.

Test Plan:
- Reset with Rx idle high for 5208 cycles -> DO=0, CLKimpr=0, LAT=0, STB=0; no CLKimpr edges.
- 32 bytes of 0xFF at 9600 baud -> after the last stop-bit sample: 256 CLKimpr rising edges, all with DO=1, then one 4-cycle LAT pulse, then one 4-cycle STB pulse.
- Bytes 0x80 then 31 bytes of 0x00 -> only the first CLKimpr rising edge has DO=1; edges 2..256 have DO=0. Confirms byte-0-first, MSB-first order.
- 6 consecutive packets (192 bytes, about 200 ms) -> exactly 6 LAT pulses and 6 STB pulses; byte counter back at 0.
- Rx low glitch of 1000 cycles, and separately a byte with stop bit 0 -> no byte counted; the following 32 valid bytes produce exactly one transmit.
- Assert RST mid-SHIFT -> all outputs 0 on the next edge; no LAT pulse; the next full 32-byte packet transmits normally.

Source files
------------

// File: rtl/envia_datos_rx_pkg.sv
// Shared constants and state encodings for the UART-to-display bridge.
package envia_datos_rx_pkg;

    localparam int PKT_BYTES = 32;
    localparam int PKT_BITS  = PKT_BYTES * 8;

    // UART bit period in system clocks.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_LATCH,
        TX_STROBE
    } tx_state_t;

endpackage

// File: rtl/envia_datos_rx_display_tx.sv
// Display shifter: 256 bits MSB-first with a divided shift clock, then LAT and STB pulses.
module envia_datos_rx_display_tx
    import envia_datos_rx_pkg::*;
#(
    parameter int SHIFT_DIV  = 4,
    parameter int LAT_CYCLES = 4,
    parameter int STB_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PKT_BITS-1:0] load_data,
    output logic                sdo,
    output logic                sclk,
    output logic                lat,
    output logic                stb
);

    localparam int BW = $clog2(PKT_BITS);
    localparam logic [7:0]    DIV_LAST = 8'(SHIFT_DIV - 1);
    localparam logic [7:0]    LAT_LAST = 8'(LAT_CYCLES - 1);
    localparam logic [7:0]    STB_LAST = 8'(STB_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(PKT_BITS - 1);

    tx_state_t           state, state_n;
    logic [PKT_BITS-1:0] shreg, shreg_n;
    logic [7:0]          div, div_n, cnt, cnt_n;
    logic [BW-1:0]       bit_cnt, bit_n;
    logic                sdo_n, sclk_n, lat_n, stb_n;

    // State, counters and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            shreg   <= '0;
            div     <= '0;
            cnt     <= '0;
            bit_cnt <= '0;
            sdo     <= 1'b0;
            sclk    <= 1'b0;
            lat     <= 1'b0;
            stb     <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            div     <= div_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            sdo     <= sdo_n;
            sclk    <= sclk_n;
            lat     <= lat_n;
            stb     <= stb_n;
        end
    end

    // Next-state logic: data changes only on the falling shift-clock phase; loads outside IDLE are dropped.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        div_n   = div;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        sdo_n   = sdo;
        sclk_n  = sclk;
        lat_n   = lat;
        stb_n   = stb;
        case (state)
            TX_IDLE: begin
                if (load) begin
                    state_n = TX_SHIFT;
                    shreg_n = load_data;
                    sdo_n   = load_data[PKT_BITS-1];
                    sclk_n  = 1'b0;
                    div_n   = '0;
                    bit_n   = '0;
                end
            end
            TX_SHIFT: begin
                if (div == DIV_LAST) begin
                    div_n = '0;
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = TX_LATCH;
                            sdo_n   = 1'b0;
                            lat_n   = 1'b1;
                            cnt_n   = '0;
                        end else begin
                            bit_n   = bit_cnt + 1'b1;
                            shreg_n = {shreg[PKT_BITS-2:0], 1'b0};
                            sdo_n   = shreg[PKT_BITS-2];
                        end
                    end
                end else begin
                    div_n = div + 8'd1;
                end
            end
            TX_LATCH: begin
                if (cnt == LAT_LAST) begin
                    state_n = TX_STROBE;
                    lat_n   = 1'b0;
                    stb_n   = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            TX_STROBE: begin
                if (cnt == STB_LAST) begin
                    state_n = TX_IDLE;
                    stb_n   = 1'b0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/envia_datos_rx_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle valid pulse.
module envia_datos_rx_uart_rx
    import envia_datos_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic       rx_s1, rx_s2, rx_d;
    rx_state_t  state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] data_n;
    logic       valid_n;

    // Synchronize the asynchronous line; rx_d keeps the previous synced value for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            rx_data  <= data_n;
            rx_valid <= valid_n;
        end
    end

    // Next-state logic: start bit is re-checked at half a bit, data/stop at full-bit intervals.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        data_n    = rx_data;
        valid_n   = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                if (rx_d && !rx_s2) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s2, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                    else bit_idx_n = bit_idx + 3'd1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    if (rx_s2) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/envia_datos_rx.sv
// UART-to-display bridge: packs received bytes into 32-byte packets and shifts each one out.
module envia_datos_rx
    import envia_datos_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int SHIFT_DIV  = 4,
    parameter int LAT_CYCLES = 4,
    parameter int STB_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic Rx,
    output logic DO,
    output logic CLKimpr,
    output logic LAT,
    output logic STB
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW = $clog2(PKT_BYTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(PKT_BYTES - 1);

    logic [7:0]                 rx_data;
    logic                       rx_valid;
    logic [PKT_BYTES-1:0][7:0]  pkt_buf;
    logic [PKT_BYTES-1:0][7:0]  snap_bytes;
    logic [CW-1:0]              byte_cnt;
    logic                       snap_load;

    envia_datos_rx_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (CLK),
        .rst      (RST),
        .rx       (Rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    // Snapshot includes the byte arriving this cycle; byte 0 sits in the top bits so it shifts first.
    always_comb begin
        snap_bytes = '0;
        for (int k = 0; k < PKT_BYTES; k++)
            snap_bytes[PKT_BYTES-1-k] = (k == PKT_BYTES - 1) ? rx_data : pkt_buf[k];
    end

    assign snap_load = rx_valid && (byte_cnt == CNT_LAST);

    // Packing buffer: valid bytes land in their slot; counter wraps after the last slot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pkt_buf  <= '0;
            byte_cnt <= '0;
        end else if (rx_valid) begin
            pkt_buf[byte_cnt] <= rx_data;
            byte_cnt          <= (byte_cnt == CNT_LAST) ? '0 : byte_cnt + 1'b1;
        end
    end

    envia_datos_rx_display_tx #(
        .SHIFT_DIV  (SHIFT_DIV),
        .LAT_CYCLES (LAT_CYCLES),
        .STB_CYCLES (STB_CYCLES)
    ) u_tx (
        .clk       (CLK),
        .rst       (RST),
        .load      (snap_load),
        .load_data (snap_bytes),
        .sdo       (DO),
        .sclk      (CLKimpr),
        .lat       (LAT),
        .stb       (STB)
    );

endmodule

// File: tb/tb_envia_datos_rx.sv
// Bench for envia_datos_rx at a scaled baud rate (16 clocks per UART bit).
module tb_envia_datos_rx;

    localparam int CPB = 16;

    typedef struct {
        logic [255:0] bits;
        int nbits;
        int lat_w;
        int stb_w;
        int bad;
    } frame_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic Rx  = 1'b1;
    logic DO, CLKimpr, LAT, STB;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: pending bytes and expected 256-bit frames.
    logic [7:0]   pend[$];
    logic [255:0] exp_frames[$];

    // Monitor state.
    frame_t       mon_frames[$];
    frame_t       mfr;
    logic [255:0] cur;
    int cur_n = 0, clk_rises = 0, lat_cnt = 0, stb_cnt = 0;
    int lat_w = 0, stb_w = 0, bad = 0;
    logic p_clk = 1'b0, p_lat = 1'b0, p_stb = 1'b0;

    envia_datos_rx #(
        .CLK_FREQ   (160),
        .BAUD       (10),
        .SHIFT_DIV  (4),
        .LAT_CYCLES (4),
        .STB_CYCLES (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Rx      (Rx),
        .DO      (DO),
        .CLKimpr (CLKimpr),
        .LAT     (LAT),
        .STB     (STB)
    );

    always #5 CLK = ~CLK;

    // Observe the display interface on the falling clock edge.
    always @(negedge CLK) begin
        if (RST) begin
            cur_n = 0; lat_w = 0; stb_w = 0; bad = 0;
        end else begin
            if (CLKimpr && !p_clk) begin
                cur = {cur[254:0], DO};
                cur_n++;
                clk_rises++;
            end
            if (LAT && !p_lat) begin
                mfr.bits = cur; mfr.nbits = cur_n; cur_n = 0; lat_cnt++;
            end
            if (LAT) begin
                lat_w++;
                if (DO || CLKimpr) bad++;
            end
            if (STB) stb_w++;
            if (!STB && p_stb) begin
                mfr.lat_w = lat_w; mfr.stb_w = stb_w; mfr.bad = bad;
                mon_frames.push_back(mfr);
                lat_w = 0; stb_w = 0; bad = 0; stb_cnt++;
            end
        end
        p_clk = CLKimpr; p_lat = LAT; p_stb = STB;
    end

    // Model: every 32 good bytes form one frame, byte 0 first, MSB first.
    task automatic model_push(input logic [7:0] b);
        logic [255:0] f;
        pend.push_back(b);
        if (pend.size() == 32) begin
            f = '0;
            foreach (pend[k]) f = {f[247:0], pend[k]};
            exp_frames.push_back(f);
            pend.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        Rx = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            repeat (CPB) @(negedge CLK);
        end
        Rx = stop_bit;
        repeat (CPB) @(negedge CLK);
        Rx = 1'b1;
        repeat (stop_bit ? 2 : CPB) @(negedge CLK);
        if (stop_bit) model_push(b);
    endtask

    task automatic wait_frames(input int n, output bit ok);
        int t = 0;
        while (mon_frames.size() < n && t < 8000) begin
            @(negedge CLK);
            t++;
        end
        ok = (mon_frames.size() >= n);
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset;
        int e0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++; if (DO !== 1'b0) $display("FAIL reset_DO: got %b want 0", DO); else n_pass++;
        n_checks++; if (CLKimpr !== 1'b0) $display("FAIL reset_CLKimpr: got %b want 0", CLKimpr); else n_pass++;
        n_checks++; if (LAT !== 1'b0) $display("FAIL reset_LAT: got %b want 0", LAT); else n_pass++;
        n_checks++; if (STB !== 1'b0) $display("FAIL reset_STB: got %b want 0", STB); else n_pass++;
        RST = 1'b0;
        e0 = clk_rises;
        repeat (20 * CPB) @(negedge CLK);
        n_checks++; if (clk_rises != e0) $display("FAIL idle_edges: got %0d want %0d", clk_rises, e0); else n_pass++;
        n_checks++; if (lat_cnt != 0) $display("FAIL idle_lat: got %0d want 0", lat_cnt); else n_pass++;
    endtask

    task automatic test_all_ones;
        bit ok;
        frame_t fr;
        logic [255:0] ef;
        for (int i = 0; i < 32; i++) send_byte(8'hFF, 1'b1);
        wait_frames(1, ok);
        n_checks++; if (!ok) $display("FAIL ones_timeout: got %0d frames want 1", mon_frames.size()); else n_pass++;
        while (mon_frames.size() > 0 && exp_frames.size() > 0) begin
            fr = mon_frames.pop_front(); ef = exp_frames.pop_front();
            n_checks++; if (fr.bits !== ef) $display("FAIL ones_data: got %h want %h", fr.bits, ef); else n_pass++;
            n_checks++; if (fr.nbits != 256) $display("FAIL ones_edges: got %0d want 256", fr.nbits); else n_pass++;
            n_checks++; if (fr.lat_w != 4) $display("FAIL ones_lat_w: got %0d want 4", fr.lat_w); else n_pass++;
            n_checks++; if (fr.stb_w != 4) $display("FAIL ones_stb_w: got %0d want 4", fr.stb_w); else n_pass++;
            n_checks++; if (fr.bad != 0) $display("FAIL ones_latch_idle: got %0d want 0", fr.bad); else n_pass++;
        end
        n_checks++;
        if (mon_frames.size() != 0 || exp_frames.size() != 0)
            $display("FAIL ones_count: got %0d/%0d left want 0/0", mon_frames.size(), exp_frames.size());
        else n_pass++;
    endtask

    task automatic test_msb_order;
        bit ok;
        frame_t fr;
        logic [255:0] ef;
        send_byte(8'h80, 1'b1);
        for (int i = 1; i < 32; i++) send_byte(8'h00, 1'b1);
        wait_frames(1, ok);
        n_checks++; if (!ok) $display("FAIL order_timeout: got %0d frames want 1", mon_frames.size()); else n_pass++;
        while (mon_frames.size() > 0 && exp_frames.size() > 0) begin
            fr = mon_frames.pop_front(); ef = exp_frames.pop_front();
            n_checks++; if (fr.bits !== ef) $display("FAIL order_data: got %h want %h", fr.bits, ef); else n_pass++;
            n_checks++; if (fr.nbits != 256) $display("FAIL order_edges: got %0d want 256", fr.nbits); else n_pass++;
            n_checks++; if (fr.lat_w != 4 || fr.stb_w != 4) $display("FAIL order_pulses: got %0d/%0d want 4/4", fr.lat_w, fr.stb_w); else n_pass++;
        end
        n_checks++;
        if (mon_frames.size() != 0 || exp_frames.size() != 0)
            $display("FAIL order_count: got %0d/%0d left want 0/0", mon_frames.size(), exp_frames.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        bit ok;
        frame_t fr;
        logic [255:0] ef;
        int l0, s0;
        l0 = lat_cnt; s0 = stb_cnt;
        for (int i = 0; i < 6 * 32; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        wait_frames(6, ok);
        n_checks++; if (!ok) $display("FAIL b2b_timeout: got %0d frames want 6", mon_frames.size()); else n_pass++;
        n_checks++; if (lat_cnt - l0 != 6) $display("FAIL b2b_lat_pulses: got %0d want 6", lat_cnt - l0); else n_pass++;
        n_checks++; if (stb_cnt - s0 != 6) $display("FAIL b2b_stb_pulses: got %0d want 6", stb_cnt - s0); else n_pass++;
        while (mon_frames.size() > 0 && exp_frames.size() > 0) begin
            fr = mon_frames.pop_front(); ef = exp_frames.pop_front();
            n_checks++; if (fr.bits !== ef) $display("FAIL b2b_data: got %h want %h", fr.bits, ef); else n_pass++;
            n_checks++; if (fr.nbits != 256) $display("FAIL b2b_edges: got %0d want 256", fr.nbits); else n_pass++;
        end
        n_checks++;
        if (mon_frames.size() != 0 || exp_frames.size() != 0 || pend.size() != 0)
            $display("FAIL b2b_count: got %0d/%0d/%0d left want 0/0/0", mon_frames.size(), exp_frames.size(), pend.size());
        else n_pass++;
    endtask

    task automatic test_glitch_framing;
        bit ok;
        frame_t fr;
        logic [255:0] ef;
        int l0;
        l0 = lat_cnt;
        Rx = 1'b0;
        repeat (3) @(negedge CLK);
        Rx = 1'b1;
        repeat (2 * CPB) @(negedge CLK);
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 32; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        wait_frames(1, ok);
        n_checks++; if (!ok) $display("FAIL glitch_timeout: got %0d frames want 1", mon_frames.size()); else n_pass++;
        n_checks++; if (lat_cnt - l0 != 1) $display("FAIL glitch_lat_pulses: got %0d want 1", lat_cnt - l0); else n_pass++;
        while (mon_frames.size() > 0 && exp_frames.size() > 0) begin
            fr = mon_frames.pop_front(); ef = exp_frames.pop_front();
            n_checks++; if (fr.bits !== ef) $display("FAIL glitch_data: got %h want %h", fr.bits, ef); else n_pass++;
        end
        n_checks++;
        if (mon_frames.size() != 0 || exp_frames.size() != 0)
            $display("FAIL glitch_count: got %0d/%0d left want 0/0", mon_frames.size(), exp_frames.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_shift;
        bit ok;
        frame_t fr;
        logic [255:0] ef;
        int t, l0;
        for (int i = 0; i < 32; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        t = 0;
        while (cur_n < 100 && t < 8000) begin
            @(negedge CLK);
            t++;
        end
        n_checks++; if (cur_n < 100) $display("FAIL rst_shift_timeout: got %0d edges want 100", cur_n); else n_pass++;
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({DO, CLKimpr, LAT, STB} !== 4'b0000)
            $display("FAIL rst_shift_outputs: got %b want 0000", {DO, CLKimpr, LAT, STB});
        else n_pass++;
        RST = 1'b0;
        pend.delete();
        exp_frames.delete();
        l0 = lat_cnt;
        repeat (2500) @(negedge CLK);
        n_checks++; if (lat_cnt != l0) $display("FAIL rst_shift_no_lat: got %0d want %0d", lat_cnt, l0); else n_pass++;
        for (int i = 0; i < 32; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        wait_frames(1, ok);
        n_checks++; if (!ok) $display("FAIL rst_recover_timeout: got %0d frames want 1", mon_frames.size()); else n_pass++;
        while (mon_frames.size() > 0 && exp_frames.size() > 0) begin
            fr = mon_frames.pop_front(); ef = exp_frames.pop_front();
            n_checks++; if (fr.bits !== ef) $display("FAIL rst_recover_data: got %h want %h", fr.bits, ef); else n_pass++;
            n_checks++; if (fr.nbits != 256) $display("FAIL rst_recover_edges: got %0d want 256", fr.nbits); else n_pass++;
        end
        n_checks++;
        if (mon_frames.size() != 0 || exp_frames.size() != 0)
            $display("FAIL rst_recover_count: got %0d/%0d left want 0/0", mon_frames.size(), exp_frames.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_msb_order();
        test_back_to_back();
        test_glitch_framing();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
